// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one multi-cycle ALU among NREQ requesters
module alu_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [4*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]        rsp_result,
  output logic                    rsp_carry,
  output logic                    rsp_err,
  output logic                    alu_start,
  output logic [3:0]              alu_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  input  logic                    alu_done,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic                    alu_carry,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_owner;
  logic [TW-1:0]   r_timer;

  logic            w_found;
  logic [PW-1:0]   w_grant;
  logic [PW-1:0]   w_next_ptr;
  logic [3:0]      w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic            w_legal;
  logic            w_owner_ack;
  logic            w_timeout;

  // Round-robin search: first valid requester starting at r_rr_ptr, wrapping modulo NREQ
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = PW'(idx);
      end
    end
  end

  assign w_op        = req_op[4*w_grant +: 4];
  assign w_a         = req_a[WIDTH*w_grant +: WIDTH];
  assign w_b         = req_b[WIDTH*w_grant +: WIDTH];
  assign w_legal     = (int'(w_op) < NUM_OPS);
  assign w_next_ptr  = (w_grant == PW'(NREQ-1)) ? '0 : w_grant + 1'b1;
  assign w_owner_ack = rsp_ready[r_owner];
  assign w_timeout   = (r_timer == TW'(TIMEOUT-1));

  // Grant and response strobes are decoded from state so they drop the moment the state moves
  assign req_ready = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_grant) : '0;
  assign rsp_valid = (r_state == S_RESP) ? (NREQ'(1) << r_owner) : '0;
  assign busy      = (r_state != S_IDLE);

  // Main FSM: grant, issue pulse, wait for done/timeout, hold response until the owner accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_timer    <= '0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            alu_op   <= w_op;
            alu_a    <= w_a;
            alu_b    <= w_b;
            r_owner  <= w_grant;
            r_rr_ptr <= w_next_ptr;
            if (w_legal) begin
              alu_start <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              // Illegal opcode is answered directly without touching the ALU
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              r_state    <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          // alu_done here is ignored: the ALU takes at least one cycle after start
          alu_start <= 1'b0;
          r_timer   <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_err    <= 1'b0;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            rsp_err    <= 1'b1;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            r_state    <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (w_owner_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_carry;
  logic                  rsp_err;
  logic                  alu_start;
  logic [3:0]            alu_op;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic                  alu_done;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_carry;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  alu_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NUM_OPS(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_carry(alu_carry),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here, checks follow #2 later
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    alu_done = 1'b0; alu_result = '0; alu_carry = 1'b0;
    #3;
    checks++;
    if ({req_ready, rsp_valid, busy, alu_start} !== 10'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0", {req_ready, rsp_valid, busy, alu_start});
    end
    checks++;
    if ({alu_op, alu_a, alu_b, rsp_result, rsp_carry, rsp_err} !== 30'b0) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0", {alu_op, alu_a, alu_b, rsp_result, rsp_carry, rsp_err});
    end
    cyc; cyc;
    rst = 1'b0;
  endtask

  task automatic test_single;
    req_op[11:8] = 4'h0; req_a[23:16] = 8'h35; req_b[23:16] = 8'h0A;
    req_valid = 4'b0100;
    #2;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    cyc; req_valid = '0; #2;
    checks++;
    if ({alu_start, alu_op, alu_a, alu_b, req_ready} !== {1'b1, 4'h0, 8'h35, 8'h0A, 4'b0000}) begin
      errors++; $display("FAIL single_issue: got start=%b op=%h a=%h b=%h ready=%b expected 1/0/35/0a/0000",
                         alu_start, alu_op, alu_a, alu_b, req_ready);
    end
    cyc; #2;
    checks++;
    if ({alu_start, busy} !== 2'b01) begin errors++; $display("FAIL single_start_pulse: got start=%b busy=%b expected 0 1", alu_start, busy); end
    cyc;
    cyc; alu_done = 1'b1; alu_result = 8'h3F; #2;
    checks++;
    if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid); end
    cyc; alu_done = 1'b0; alu_result = 8'h00; #2;
    checks++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_err} !== {4'b0100, 8'h3F, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_rsp: got v=%b r=%h c=%b e=%b expected 0100/3f/0/0", rsp_valid, rsp_result, rsp_carry, rsp_err);
    end
    rsp_ready = 4'b0100;
    cyc; rsp_ready = '0; #2;
    checks++;
    if ({rsp_valid, busy} !== 5'b0) begin errors++; $display("FAIL single_done: got v=%b busy=%b expected 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin;
    logic [7:0] a_tab [4];
    logic [7:0] b_tab [4];
    logic [7:0] r_tab [4];
    int g;
    a_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
    b_tab = '{8'h01, 8'h02, 8'h03, 8'h04};
    r_tab = '{8'h12, 8'h24, 8'h36, 8'h48};
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_op[4*i +: 4] = 4'(i);
      req_a[8*i +: 8]  = a_tab[i];
      req_b[8*i +: 8]  = b_tab[i];
    end
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      #2;
      checks++;
      if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, 4'(1 << g)); end
      cyc; #2;
      checks++;
      if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 4'(g), a_tab[g], b_tab[g]}) begin
        errors++; $display("FAIL rr_issue%0d: got start=%b op=%h a=%h b=%h expected 1/%h/%h/%h",
                           n, alu_start, alu_op, alu_a, alu_b, 4'(g), a_tab[g], b_tab[g]);
      end
      cyc; alu_done = 1'b1; alu_result = r_tab[g];
      cyc; alu_done = 1'b0; #2;
      checks++;
      if ({rsp_valid, rsp_result, rsp_err} !== {4'(1 << g), r_tab[g], 1'b0}) begin
        errors++; $display("FAIL rr_rsp%0d: got v=%b r=%h e=%b expected %b/%h/0", n, rsp_valid, rsp_result, rsp_err, 4'(1 << g), r_tab[g]);
      end
      cyc;
    end
    req_valid = '0; rsp_ready = '0; req_op = '0;
  endtask

  task automatic test_illegal_op;
    req_op[7:4] = 4'hA; req_a[15:8] = 8'h77; req_b[15:8] = 8'h66;
    req_valid = 4'b0010;
    #2;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL illegal_ready: got %b expected 0010", req_ready); end
    cyc; req_valid = '0; #2;
    checks++;
    if ({rsp_valid, rsp_err, rsp_result, alu_start, alu_op} !== {4'b0010, 1'b1, 8'h00, 1'b0, 4'hA}) begin
      errors++; $display("FAIL illegal_rsp: got v=%b e=%b r=%h start=%b op=%h expected 0010/1/00/0/a",
                         rsp_valid, rsp_err, rsp_result, alu_start, alu_op);
    end
    rsp_ready = 4'b0010;
    cyc; rsp_ready = '0; req_op = '0; #2;
    checks++;
    if ({rsp_valid, busy} !== 5'b0) begin errors++; $display("FAIL illegal_done: got v=%b busy=%b expected 0", rsp_valid, busy); end
  endtask

  task automatic test_timeout;
    req_op[3:0] = 4'h1; req_a[7:0] = 8'h5A; req_b[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #2;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL timeout_ready: got %b expected 0001", req_ready); end
    cyc; req_valid = '0; #2;
    checks++;
    if (alu_start !== 1'b1) begin errors++; $display("FAIL timeout_start: got %b expected 1", alu_start); end
    for (int k = 0; k < 16; k++) cyc;
    #2;
    checks++;
    if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL timeout_early: got %b expected 0000", rsp_valid); end
    cyc; #2;
    checks++;
    if ({rsp_valid, rsp_err, rsp_result, rsp_carry} !== {4'b0001, 1'b1, 8'h00, 1'b0}) begin
      errors++; $display("FAIL timeout_rsp: got v=%b e=%b r=%h c=%b expected 0001/1/00/0", rsp_valid, rsp_err, rsp_result, rsp_carry);
    end
    rsp_ready = 4'b0001;
    cyc; rsp_ready = '0; alu_done = 1'b1; alu_result = 8'h55;
    cyc; alu_done = 1'b0; alu_result = 8'h00;
    cyc; #2;
    checks++;
    if ({rsp_valid, busy, alu_start} !== 6'b0) begin
      errors++; $display("FAIL stray_done: got v=%b busy=%b start=%b expected 0", rsp_valid, busy, alu_start);
    end
  endtask

  task automatic test_backpressure;
    req_op[3:0] = 4'h2; req_a[7:0] = 8'h80; req_b[7:0] = 8'h81;
    req_valid = 4'b0001;
    #2;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready0: got %b expected 0001", req_ready); end
    cyc;
    req_valid = 4'b1000; req_op[15:12] = 4'h3; req_a[31:24] = 8'h12; req_b[31:24] = 8'h34;
    #2;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_issue_ready: got %b expected 0000", req_ready); end
    cyc; alu_done = 1'b1; alu_result = 8'h01; alu_carry = 1'b1;
    cyc; alu_done = 1'b0; alu_result = 8'hEE; alu_carry = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #2;
      checks++;
      if ({rsp_valid, rsp_result, rsp_carry, rsp_err, req_ready} !== {4'b0001, 8'h01, 1'b1, 1'b0, 4'b0000}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b r=%h c=%b e=%b rdy=%b expected 0001/01/1/0/0000",
                           k, rsp_valid, rsp_result, rsp_carry, rsp_err, req_ready);
      end
      cyc;
    end
    rsp_ready = 4'b1110;
    #2;
    checks++;
    if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL bp_nonowner_ack: got %b expected 0001", rsp_valid); end
    cyc;
    rsp_ready = 4'b0001;
    cyc; rsp_ready = '0; #2;
    checks++;
    if ({rsp_valid, req_ready} !== {4'b0000, 4'b1000}) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b expected 0000/1000", rsp_valid, req_ready);
    end
    cyc; req_valid = '0; #2;
    checks++;
    if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 4'h3, 8'h12, 8'h34}) begin
      errors++; $display("FAIL bp_req3_issue: got start=%b op=%h a=%h b=%h expected 1/3/12/34", alu_start, alu_op, alu_a, alu_b);
    end
    cyc; alu_done = 1'b1; alu_result = 8'h46;
    cyc; alu_done = 1'b0; rsp_ready = 4'b1000;
    cyc; rsp_ready = '0; req_op = '0;
  endtask

  task automatic test_reset_mid_op;
    req_op[7:4] = 4'h4; req_a[15:8] = 8'hC3; req_b[15:8] = 8'h3C;
    req_valid = 4'b0010;
    cyc; req_valid = '0;
    cyc;
    cyc;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, alu_start, alu_op, alu_a, alu_b, rsp_result, rsp_carry, rsp_err, rsp_valid, req_ready} !== 40'b0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%b op=%h a=%h b=%h v=%b expected all 0", busy, alu_op, alu_a, alu_b, rsp_valid);
    end
    cyc; rst = 1'b0;
    alu_done = 1'b1; alu_result = 8'h99;
    cyc; alu_done = 1'b0;
    cyc; #2;
    checks++;
    if ({rsp_valid, busy} !== 5'b0) begin errors++; $display("FAIL midreset_done_ignored: got v=%b busy=%b expected 0", rsp_valid, busy); end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL midreset_next_grant: got %b expected 0001", req_ready); end
    req_valid = '0;
    cyc;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_illegal_op;
    test_timeout;
    test_backpressure;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one multi-cycle ALU among NREQ requesters.
- Round-robin grant, one operation outstanding at a time.
- Captures operands, issues a single-cycle start pulse to the ALU, waits for done or timeout, then returns the result to the owning requester with a valid/ready handshake.
- Sits between the requester ports and the ALU datapath in the ALU subsystem.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: operand and result width.
- NUM_OPS, 8: legal opcodes are 0..NUM_OPS-1; opcode width is fixed at 4.
- TIMEOUT, 16: maximum WAIT cycles before an error response (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  4*NREQ  opcode; requester i uses slice [4i+3:4i].
- req_a  in  WIDTH*NREQ  operand A slices.
- req_b  in  WIDTH*NREQ  operand B slices.
- rsp_valid  out  NREQ  response valid to owner; one-hot or zero.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_result  out  WIDTH  result, shared bus.
- rsp_carry  out  1  carry/flag, shared bus.
- rsp_err  out  1  1 = illegal opcode or timeout.
- alu_start  out  1  one-cycle issue pulse.
- alu_op  out  4  registered opcode.
- alu_a  out  WIDTH  registered operand A.
- alu_b  out  WIDTH  registered operand B.
- alu_done  in  1  ALU completion pulse.
- alu_result  in  WIDTH  valid when alu_done=1.
- alu_carry  in  1  valid when alu_done=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; rr_ptr=0; owner=0; timer=0.
  - All registered outputs 0 (alu_start, alu_op/a/b, rsp_result, rsp_carry, rsp_err); req_ready=0; rsp_valid=0; busy=0.
  - Reset mid-operation abandons the operation; no response is issued, and a later alu_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[g]=1 combinationally; only in IDLE, only for the winner.
  - On that edge: capture op/a/b into alu_op/alu_a/alu_b; owner<=g; rr_ptr<=(g+1) mod NREQ.
  - Next state: ISSUE if op<NUM_OPS; otherwise RESP with rsp_err=1, rsp_result=0, rsp_carry=0 (ALU untouched).
  - No req_valid: stay in IDLE, rr_ptr unchanged.
- ISSUE: alu_start=1 for exactly this cycle; timer<=0; next state WAIT. alu_done in ISSUE is ignored (ALU minimum latency 1).
- WAIT:
  - alu_done=1: rsp_result<=alu_result, rsp_carry<=alu_carry, rsp_err<=0, go RESP.
  - Else if timer==TIMEOUT-1: rsp_err<=1, rsp_result<=0, rsp_carry<=0, go RESP.
  - Else timer<=timer+1.
  - alu_done wins if it coincides with the timeout cycle.
- RESP:
  - rsp_valid[owner]=1; rsp_result/carry/err held stable.
  - On rsp_ready[owner]=1, go IDLE; the next grant is possible on the following cycle.
  - rsp_ready from non-owners is ignored. alu_done in RESP/IDLE (late or stray) is ignored.
- Latency:
  - Request accepted at edge T → alu_start high in cycle T+1.
  - alu_done at cycle T+1+L (L≥1) → rsp_valid from cycle T+2+L.
  - Illegal opcode → rsp_valid in cycle T+1.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Requesters hold req_valid and operands stable until accepted; the arbiter does not check this.

Test Plan:
- Single request: requester 2, op=0, A=8'h35, B=8'h0A; ALU returns 8'h3F after L=3 → req_ready[2] one cycle; alu_start 1 cycle later with 0/35/0A; rsp_valid[2] 5 cycles after accept with result 3F, err=0.
- All 4 requesters held valid from reset, ALU L=1, rsp_ready tied 1 → grants in order 0,1,2,3,0; never two req_ready bits set together.
- Illegal opcode 4'hA (NUM_OPS=8) from requester 1 → no alu_start; rsp_valid[1] next cycle with err=1, result=0.
- ALU never asserts done → rsp_err=1 after 16 WAIT cycles; then alu_done injected in IDLE → ignored, no response.
- Backpressure: rsp_ready[0] held low 10 cycles → rsp_valid[0] and result stay stable, req_valid[3] not accepted until the handshake completes.
- Reset asserted in WAIT → all outputs 0 immediately; subsequent alu_done ignored; next request granted to requester 0.
